shift_counter_n: RTL and testbench
==================================

# shift_counter_n

Parametrised ring/Johnson shift counter built on the team's flop-with-reset and flop-with-load style. It is a single WIDTH-bit state register that advances one step per enabled clock. The mode input selects ring (one-hot rotation) or Johnson (twisted-ring) sequencing, and the direction input selects left or right shift. It adds parallel load, a position counter with a wrap pulse, illegal-state detection and optional self-correction. It is the general counter used wherever the fixed 16-bit ring/Johnson counters were instantiated.

## Interface
- WIDTH, 16: state register width; legal range WIDTH ≥ 2.
- SELF_CORRECT, 1: when 1, an enabled shift from an illegal state reloads the seed instead of shifting. When 0, an illegal state shifts as-is.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high; one clock; no asynchronous paths.
- en  input  1  advance one step this cycle.
- load  input  1  parallel load of din this cycle.
- mode  input  1  0 = ring, 1 = Johnson.
- dir  input  1  0 = shift toward MSB (left), 1 = shift toward LSB (right).
- din  input  WIDTH  parallel load value.
- q  output  WIDTH  counter state, registered.
- pos  output  clog2(2·WIDTH)  shifts since last seed/load, registered.
- wrap  output  1  one-cycle pulse, registered.
- illegal  output  1  combinational decode of the current q and mode.

## Operation
- Seed(mode): ring = WIDTH'b0…01; Johnson = all zeros. Period(mode): ring = WIDTH; Johnson = 2·WIDTH.
- Priority each rising edge: reset > load > en > hold.
- reset: q ← Seed(mode as sampled that edge), pos ← 0, wrap ← 0.
- load: q ← din, pos ← 0, wrap ← 0. The en input is ignored that cycle.
- en, state legal (or SELF_CORRECT=0):
  - Ring left: q ← {q[W-2:0], q[W-1]}.
  - Ring right: q ← {q[0], q[W-1:1]}.
  - Johnson left: q ← {q[W-2:0], ~q[W-1]}.
  - Johnson right: q ← {~q[0], q[W-1:1]}.
- Position counter: when pos ≥ Period(mode)−1, pos ← 0 and wrap ← 1. Otherwise pos ← pos+1 and wrap ← 0. pos counts shifts regardless of dir.
- en, state illegal, SELF_CORRECT=1: q ← Seed(mode), pos ← 0, wrap ← 0.
- Hold (no reset/load/en): q and pos unchanged; wrap ← 0.
- illegal, ring: popcount(q) ≠ 1.
- illegal, Johnson: count of i in [0, W-2] with q[i] ≠ q[i+1] exceeds 1.
- mode and dir may change any cycle and take effect on that cycle's shift. There is no flush and q is not cleared.
- After a ring→Johnson switch on a one-hot q, q may be illegal. Self-correction handles this on the next enabled shift.
- A Johnson→ring switch with pos ≥ WIDTH−1 wraps on the next enabled shift by the ≥ rule above.

## Timing
- Reset values: q = Seed(mode), pos = 0, wrap = 0. illegal then reflects q: 0 after reset in either mode.
- Latency of one cycle from en/load/reset to q, pos and wrap.
- wrap is high exactly in the cycle after the shift that returned pos to 0. It is never high two cycles in a row unless Period is 1, which is impossible since WIDTH ≥ 2.
- illegal has zero latency from q; it is not registered.
- reset asserted mid-sequence overrides any pending load or en on the same edge.
- load and en together: load wins. pos clears and wrap does not fire.
- Continuous en with no mode change: q repeats exactly every Period(mode) cycles and wrap pulses once per period.

## Test plan
- WIDTH=4, mode=0, dir=0, reset then en×4:
  - q = 0010, 0100, 1000, 0001.
  - pos = 1, 2, 3, 0.
  - wrap=1 only in the cycle q returns to 0001.
- WIDTH=4, mode=1, dir=0, reset then en×8:
  - q = 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000.
  - wrap pulses once, after the 8th shift.
- WIDTH=4, mode=1, dir=1, reset then en×4:
  - q = 1000, 1100, 1110, 1111.
  - Toggling dir to 0 next cycle → q = 1110.
- Ring mode, load din=0101:
  - illegal=1 immediately.
  - With SELF_CORRECT=1, next en → q=0001, pos=0, illegal=0.
  - With SELF_CORRECT=0, next en (left) → q=1010.
- Ring mode, q=0100:
  - load=1, en=1, din=1000 → q=1000, pos=0.
  - reset=1 with load=1 on the same edge → q=0001.
- Johnson mode at pos=6, en held:
  - Switch mode to ring → next shift sets pos=0 and wrap=1.
  - illegal reflects the resulting q under ring rules.

Source files
------------

// File: rtl/shift_counter_n.sv
// Parametrised ring/Johnson shift counter with parallel load, position counter, wrap pulse,
// illegal-state decode and optional self-correction back to the mode's seed.
module shift_counter_n #(
  parameter int unsigned WIDTH        = 16,
  parameter bit          SELF_CORRECT = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic                          load,
  input  logic                          mode,
  input  logic                          dir,
  input  logic [WIDTH-1:0]              din,
  output logic [WIDTH-1:0]              q,
  output logic [$clog2(2*WIDTH)-1:0]    pos,
  output logic                          wrap,
  output logic                          illegal
);

  localparam int unsigned PosW = $clog2(2 * WIDTH);
  localparam logic [PosW-1:0] RingLast = PosW'(WIDTH - 1);
  localparam logic [PosW-1:0] JohnLast = PosW'(2 * WIDTH - 1);

  logic [WIDTH-1:0] seed;
  logic [WIDTH-1:0] shifted;
  logic [PosW-1:0]  last;
  logic [WIDTH-2:0] edges;

  always_comb begin
    seed    = mode ? '0 : WIDTH'(1);
    last    = mode ? JohnLast : RingLast;
    shifted = q;
    case ({mode, dir})
      2'b00:   shifted = {q[WIDTH-2:0], q[WIDTH-1]};
      2'b01:   shifted = {q[0], q[WIDTH-1:1]};
      2'b10:   shifted = {q[WIDTH-2:0], ~q[WIDTH-1]};
      default: shifted = {~q[0], q[WIDTH-1:1]};
    endcase
    // A legal Johnson word has at most one boundary between its run of ones and zeros.
    edges = q[WIDTH-2:0] ^ q[WIDTH-1:1];
    if (mode) begin
      illegal = $countones(edges) > 1;
    end else begin
      illegal = $countones(q) != 1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q    <= seed;
      pos  <= '0;
      wrap <= 1'b0;
    end else if (load) begin
      q    <= din;
      pos  <= '0;
      wrap <= 1'b0;
    end else if (en) begin
      if (SELF_CORRECT && illegal) begin
        q    <= seed;
        pos  <= '0;
        wrap <= 1'b0;
      end else begin
        q <= shifted;
        // >= so a Johnson-to-ring switch with a large pos still wraps.
        if (pos >= last) begin
          pos  <= '0;
          wrap <= 1'b1;
        end else begin
          pos  <= pos + PosW'(1);
          wrap <= 1'b0;
        end
      end
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shift_counter_n.sv
// Bench for shift_counter_n: two WIDTH=4 instances (self-correcting and not) checked against
// an arithmetic reference model plus directed expectations.
module tb_shift_counter_n;

  localparam int W = 4;

  logic clk = 1'b0;
  logic reset, en, load, mode, dir;
  logic [W-1:0] din;
  logic [W-1:0] q0, q1;
  logic [2:0]   pos0, pos1;
  logic         wrap0, wrap1, ill0, ill1;
  logic [8:0]   obs0, obs1;

  int checks = 0;
  int errors = 0;

  int mq[2];
  int mpos[2];
  bit mwrap[2];

  always #5 clk = ~clk;

  shift_counter_n #(.WIDTH(W), .SELF_CORRECT(1'b1)) dut0 (
    .clk(clk), .reset(reset), .en(en), .load(load), .mode(mode), .dir(dir), .din(din),
    .q(q0), .pos(pos0), .wrap(wrap0), .illegal(ill0)
  );

  shift_counter_n #(.WIDTH(W), .SELF_CORRECT(1'b0)) dut1 (
    .clk(clk), .reset(reset), .en(en), .load(load), .mode(mode), .dir(dir), .din(din),
    .q(q1), .pos(pos1), .wrap(wrap1), .illegal(ill1)
  );

  assign obs0 = {q0, pos0, wrap0, ill0};
  assign obs1 = {q1, pos1, wrap1, ill1};

  function automatic bit m_illegal(int v, bit md);
    int n = 0;
    if (!md) begin
      for (int i = 0; i < W; i++) n += (v >> i) & 1;
      return n != 1;
    end
    for (int i = 0; i < W - 1; i++) if (((v >> i) & 1) != ((v >> (i + 1)) & 1)) n++;
    return n > 1;
  endfunction

  function automatic int m_shift(int v, bit md, bit dr);
    int msb = (v >> (W - 1)) & 1;
    int lsb = v & 1;
    int feed;
    if (!dr) begin
      feed = md ? 1 - msb : msb;
      return ((v << 1) & ((1 << W) - 1)) | feed;
    end
    feed = md ? 1 - lsb : lsb;
    return (v >> 1) | (feed << (W - 1));
  endfunction

  // Instance 0 self-corrects, instance 1 does not.
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        mq[k] = mode ? 0 : 1; mpos[k] = 0; mwrap[k] = 0;
      end else if (load) begin
        mq[k] = int'(din); mpos[k] = 0; mwrap[k] = 0;
      end else if (en) begin
        if (k == 0 && m_illegal(mq[k], mode)) begin
          mq[k] = mode ? 0 : 1; mpos[k] = 0; mwrap[k] = 0;
        end else begin
          mq[k] = m_shift(mq[k], mode, dir);
          if (mpos[k] >= (mode ? 2 * W : W) - 1) begin
            mpos[k] = 0; mwrap[k] = 1;
          end else begin
            mpos[k] = mpos[k] + 1; mwrap[k] = 0;
          end
        end
      end else begin
        mwrap[k] = 0;
      end
    end
  endtask

  function automatic logic [8:0] exp_vec(int k);
    return {4'(mq[k]), 3'(mpos[k]), mwrap[k], m_illegal(mq[k], mode)};
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    reset = 0; en = 0; load = 0; din = '0;
  endtask

  task automatic test_reset();
    idle_inputs(); reset = 1; mode = 0; dir = 0;
    step();
    checks++;
    if (obs0 !== {4'b0001, 3'd0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL reset_ring: got %b want %b", obs0, {4'b0001, 3'd0, 1'b0, 1'b0});
    end
    mode = 1;
    step();
    checks++;
    if (obs1 !== {4'b0000, 3'd0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL reset_johnson: got %b want %b", obs1, {4'b0000, 3'd0, 1'b0, 1'b0});
    end
    reset = 0;
  endtask

  task automatic test_ring_left();
    logic [3:0] tq[4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    idle_inputs(); reset = 1; mode = 0; dir = 0;
    step();
    reset = 0; en = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (obs0 !== {tq[i], 3'((i + 1) % 4), i == 3, 1'b0}) begin
        errors++; $display("FAIL ring_left[%0d]: got %b want %b", i, obs0,
                           {tq[i], 3'((i + 1) % 4), i == 3, 1'b0});
      end
      checks++;
      if (obs1 !== exp_vec(1)) begin
        errors++; $display("FAIL ring_left_model[%0d]: got %b want %b", i, obs1, exp_vec(1));
      end
    end
    en = 0;
  endtask

  task automatic test_johnson_left();
    logic [3:0] tq[8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                          4'b1110, 4'b1100, 4'b1000, 4'b0000};
    idle_inputs(); reset = 1; mode = 1; dir = 0;
    step();
    reset = 0; en = 1;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (obs0 !== {tq[i], 3'((i + 1) % 8), i == 7, 1'b0}) begin
        errors++; $display("FAIL johnson_left[%0d]: got %b want %b", i, obs0,
                           {tq[i], 3'((i + 1) % 8), i == 7, 1'b0});
      end
    end
    en = 0;
    step();
    checks++;
    if (wrap0 !== 1'b0 || q0 !== 4'b0000) begin
      errors++; $display("FAIL johnson_hold: got q=%b wrap=%b want q=0000 wrap=0", q0, wrap0);
    end
  endtask

  task automatic test_johnson_right_toggle();
    logic [3:0] tq[4] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111};
    idle_inputs(); reset = 1; mode = 1; dir = 1;
    step();
    reset = 0; en = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (q0 !== tq[i]) begin
        errors++; $display("FAIL johnson_right[%0d]: got %b want %b", i, q0, tq[i]);
      end
    end
    dir = 0;
    step();
    checks++;
    if (q0 !== 4'b1110) begin
      errors++; $display("FAIL johnson_dir_toggle: got %b want 1110", q0);
    end
    en = 0;
  endtask

  task automatic test_illegal_load();
    idle_inputs(); reset = 1; mode = 0; dir = 0;
    step();
    reset = 0; load = 1; din = 4'b0101;
    step();
    load = 0;
    checks++;
    if ({q0, ill0, q1, ill1} !== {4'b0101, 1'b1, 4'b0101, 1'b1}) begin
      errors++; $display("FAIL illegal_after_load: got %b/%b %b/%b want 0101/1 0101/1",
                         q0, ill0, q1, ill1);
    end
    en = 1;
    step();
    en = 0;
    checks++;
    if ({q0, pos0, ill0} !== {4'b0001, 3'd0, 1'b0}) begin
      errors++; $display("FAIL self_correct: got q=%b pos=%0d ill=%b want q=0001 pos=0 ill=0",
                         q0, pos0, ill0);
    end
    checks++;
    if (q1 !== 4'b1010) begin
      errors++; $display("FAIL no_correct_shift: got %b want 1010", q1);
    end
  endtask

  task automatic test_priority();
    idle_inputs(); reset = 1; mode = 0; dir = 0;
    step();
    reset = 0; en = 1;
    step(); step();
    load = 1; din = 4'b1000;
    step();
    checks++;
    if ({q0, pos0, wrap0} !== {4'b1000, 3'd0, 1'b0}) begin
      errors++; $display("FAIL load_over_en: got q=%b pos=%0d wrap=%b want q=1000 pos=0 wrap=0",
                         q0, pos0, wrap0);
    end
    reset = 1; din = 4'b0110;
    step();
    checks++;
    if (q0 !== 4'b0001 || q1 !== 4'b0001) begin
      errors++; $display("FAIL reset_over_load: got %b %b want 0001 0001", q0, q1);
    end
    idle_inputs();
  endtask

  task automatic test_mode_switch();
    idle_inputs(); reset = 1; mode = 1; dir = 0;
    step();
    reset = 0; en = 1;
    for (int i = 0; i < 6; i++) step();
    checks++;
    if (pos1 !== 3'd6 || q1 !== 4'b1100) begin
      errors++; $display("FAIL johnson_pos6: got pos=%0d q=%b want pos=6 q=1100", pos1, q1);
    end
    mode = 0;
    step();
    checks++;
    if ({q1, pos1, wrap1, ill1} !== {4'b1001, 3'd0, 1'b1, 1'b1}) begin
      errors++; $display("FAIL mode_switch_wrap: got %b want %b", {q1, pos1, wrap1, ill1},
                         {4'b1001, 3'd0, 1'b1, 1'b1});
    end
    checks++;
    if (obs0 !== exp_vec(0)) begin
      errors++; $display("FAIL mode_switch_sc: got %b want %b", obs0, exp_vec(0));
    end
    en = 0;
  endtask

  task automatic test_random();
    idle_inputs(); reset = 1; mode = 0; dir = 0;
    step();
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 49) == 0);
      load  = ($urandom_range(0, 11) == 0);
      en    = ($urandom_range(0, 9) < 7);
      dir   = 1'($urandom_range(0, 1));
      din   = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      step();
      checks++;
      if (obs0 !== exp_vec(0)) begin
        errors++; $display("FAIL random_sc[%0d]: got %b want %b", i, obs0, exp_vec(0));
      end
      checks++;
      if (obs1 !== exp_vec(1)) begin
        errors++; $display("FAIL random_nc[%0d]: got %b want %b", i, obs1, exp_vec(1));
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs(); mode = 0; dir = 0;
    test_reset();
    test_ring_left();
    test_johnson_left();
    test_johnson_right_toggle();
    test_illegal_load();
    test_priority();
    test_mode_switch();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
